// File: rtl/stopwatch_bcd_pkg.sv
// Shared types and constants for the MM:SS BCD stopwatch.
// State encodings, BCD digit limits and seven-segment patterns.
package stopwatch_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ONES_MAX = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX = 4'd5;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/stopwatch_bcd_bcd_to_7seg.sv
// BCD digit to active-low seven-segment decoder.
// Values 10..15 blank the digit.
module bcd_to_7seg
  import stopwatch_bcd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch driven by a one-second tick pulse.
// Start/stop toggles run/pause; clear forces 00:00 and IDLE.
module stopwatch_bcd
  import stopwatch_bcd_pkg::*;
#(
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic       running,
  output logic       rollover
);

  localparam logic [6:0] MAX_MIN_V = 7'(MAX_MIN);

  state_t     state;
  logic       ss_q;
  logic       ss_rise;
  logic       count_en;
  logic [6:0] min_val;
  logic       at_max;

  assign ss_rise  = start_stop & ~ss_q;
  assign count_en = (state == ST_RUN) & tick;

  // Minutes compared as binary so MAX_MIN can be any 1..99
  assign min_val = ({3'd0, min_tens} * 7'd10)
                 + {3'd0, min_ones};

  assign at_max = (min_val == MAX_MIN_V)
                & (sec_tens == BCD_TENS_MAX)
                & (sec_ones == BCD_ONES_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      running  <= 1'b0;
      ss_q     <= 1'b0;
      rollover <= 1'b0;
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
    end else begin
      ss_q     <= start_stop;
      rollover <= 1'b0;
      if (clear) begin
        state    <= ST_IDLE;
        running  <= 1'b0;
        sec_ones <= 4'd0;
        sec_tens <= 4'd0;
        min_ones <= 4'd0;
        min_tens <= 4'd0;
      end else begin
        if (count_en) begin
          if (at_max) begin
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
            rollover <= 1'b1;
          end else if (sec_ones != BCD_ONES_MAX) begin
            sec_ones <= sec_ones + 4'd1;
          end else begin
            sec_ones <= 4'd0;
            if (sec_tens != BCD_TENS_MAX) begin
              sec_tens <= sec_tens + 4'd1;
            end else begin
              sec_tens <= 4'd0;
              if (min_ones != BCD_ONES_MAX) begin
                min_ones <= min_ones + 4'd1;
              end else begin
                min_ones <= 4'd0;
                min_tens <= min_tens + 4'd1;
              end
            end
          end
        end
        if (ss_rise) begin
          case (state)
            ST_IDLE: begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
            ST_RUN: begin
              state   <= ST_PAUSE;
              running <= 1'b0;
            end
            ST_PAUSE: begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
            default: begin
              state   <= ST_IDLE;
              running <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  bcd_to_7seg u_seg0 (.bcd(sec_ones), .seg(hex0));
  bcd_to_7seg u_seg1 (.bcd(sec_tens), .seg(hex1));
  bcd_to_7seg u_seg2 (.bcd(min_ones), .seg(hex2));
  bcd_to_7seg u_seg3 (.bcd(min_tens), .seg(hex3));

endmodule
